posit_pair_decoder_pipe: RTL and testbench

- Two-stage pipelined posit decoder. Each transaction takes one weight posit and one data posit.
- Per operand it outputs sign, regime, exponent, left-aligned mantissa, combined scale and special-value flags.
- A valid/ready handshake on both sides supports backpressure, plus a synchronous flush.
- Sits between the operand fetch buffers and the posit MAC datapath. It is the stall-capable, scale-producing successor of the single-register pair decoder.

---
 rtl/posit_pair_decoder_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_posit_pair_decoder_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_pair_decoder_pipe.sv
// Two-stage posit pair decoder: S1 captures sign, magnitude, regime run and special flags,
// S2 expands them into regime, exponent, fraction and scale. Valid/ready on both sides.
module posit_pair_decoder_pipe #(
    parameter  int WIDTH = 8,
    parameter  int EXP   = 2,
    localparam int REGW  = $clog2(WIDTH) + 1,
    localparam int MTS   = WIDTH - 3 - EXP,
    localparam int SCW   = REGW + EXP
) (
    input  logic                   clk_i,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   vld_i,
    output logic                   rdy_o,
    input  logic [WIDTH-1:0]       win,
    input  logic [WIDTH-1:0]       din,
    output logic                   vld_o,
    input  logic                   rdy_i,
    output logic                   sign_w,
    output logic                   sign_d,
    output logic signed [REGW-1:0] regi_w,
    output logic signed [REGW-1:0] regi_d,
    output logic [EXP-1:0]         exp_w,
    output logic [EXP-1:0]         exp_d,
    output logic [MTS-1:0]         mts_w,
    output logic [MTS-1:0]         mts_d,
    output logic signed [SCW-1:0]  scale_w,
    output logic signed [SCW-1:0]  scale_d,
    output logic                   zero_w,
    output logic                   zero_d,
    output logic                   nar_w,
    output logic                   nar_d,
    output logic                   long_d
);

    localparam int MW = WIDTH - 1;        // magnitude width (sign stripped)
    localparam int RW = $clog2(WIDTH);    // run-length width, holds up to WIDTH-1
    localparam int FW = EXP + MTS;        // exponent + fraction field width

    typedef struct packed {
        logic          sign;
        logic [MW-1:0] mag;
        logic [RW-1:0] run;
        logic          zero;
        logic          nar;
    } s1_t;

    typedef struct packed {
        logic                   sign;
        logic signed [REGW-1:0] regi;
        logic [EXP-1:0]         expo;
        logic [MTS-1:0]         mts;
        logic signed [SCW-1:0]  scale;
        logic                   zero;
        logic                   nar;
    } s2_t;

    // Priority scan for the run of bits equal to the leading magnitude bit.
    function automatic logic [RW-1:0] run_len(input logic [MW-1:0] m);
        logic [RW-1:0] n;
        logic          stop;
        n    = '0;
        stop = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!stop && (m[i] == m[MW-1])) begin
                n = n + RW'(1);
            end else begin
                stop = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic s1_t stage1(input logic [WIDTH-1:0] x);
        s1_t           o;
        logic [MW-1:0] low;
        low    = x[MW-1:0];
        o.sign = x[WIDTH-1];
        o.mag  = x[WIDTH-1] ? -low : low;
        o.zero = (x == '0);
        o.nar  = (x == {1'b1, {MW{1'b0}}});
        o.run  = run_len(o.mag);
        return o;
    endfunction

    function automatic s2_t stage2(input s1_t s);
        s2_t                    o;
        logic [RW:0]            sh;
        logic [REGW-1:0]        rz;
        logic signed [REGW-1:0] k;
        logic [FW-1:0]          fld;
        sh  = {1'b0, s.run} + (RW + 1)'(1);
        rz  = {1'b0, s.run};
        k   = s.mag[MW-1] ? rz - REGW'(1) : REGW'(0) - rz;
        // Regime and terminator fall off the top; whatever is shifted in from the
        // right is zero, which pads a truncated exponent.
        fld = FW'((s.mag << sh) >> (MW - FW));
        o.sign  = s.sign;
        o.regi  = k;
        o.expo  = fld[FW-1 -: EXP];
        o.mts   = fld[MTS-1:0];
        o.scale = ({{EXP{k[REGW-1]}}, k} << EXP) | SCW'(o.expo);
        o.zero  = s.zero;
        o.nar   = s.nar;
        if (s.zero || s.nar) begin
            o      = '0;
            o.zero = s.zero;
            o.nar  = s.nar;
        end
        return o;
    endfunction

    logic v1_q, v1_d, v2_q, v2_d;
    s1_t  s1w_q, s1w_d, s1d_q, s1d_d;
    s2_t  s2w_q, s2w_d, s2d_q, s2d_d;
    logic dlong_q, dlong_d;
    logic adv1, adv2;
    logic long_c;

    assign adv2  = ~v2_q | rdy_i;
    assign adv1  = ~v1_q | adv2;
    assign rdy_o = adv1;
    assign vld_o = v2_q;

    assign long_c = ~(s1w_q.zero | s1w_q.nar | s1d_q.zero | s1d_q.nar) &
                    (s1d_q.run > s1w_q.run);

    // NOTE: every next-state variable is defaulted to its held value first, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        s1w_d   = s1w_q;
        s1d_d   = s1d_q;
        s2w_d   = s2w_q;
        s2d_d   = s2d_q;
        dlong_d = dlong_q;

        if (adv1) begin
            v1_d = vld_i;
            if (vld_i) begin
                s1w_d = stage1(win);
                s1d_d = stage1(din);
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2w_d   = stage2(s1w_q);
                s2d_d   = stage2(s1d_q);
                dlong_d = long_c;
            end
        end

        // Flush only kills the valid bits; data registers may keep stale contents.
        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s1w_q   <= '0;
            s1d_q   <= '0;
            s2w_q   <= '0;
            s2d_q   <= '0;
            dlong_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            s1w_q   <= s1w_d;
            s1d_q   <= s1d_d;
            s2w_q   <= s2w_d;
            s2d_q   <= s2d_d;
            dlong_q <= dlong_d;
        end
    end

    assign sign_w  = s2w_q.sign;
    assign sign_d  = s2d_q.sign;
    assign regi_w  = s2w_q.regi;
    assign regi_d  = s2d_q.regi;
    assign exp_w   = s2w_q.expo;
    assign exp_d   = s2d_q.expo;
    assign mts_w   = s2w_q.mts;
    assign mts_d   = s2d_q.mts;
    assign scale_w = s2w_q.scale;
    assign scale_d = s2d_q.scale;
    assign zero_w  = s2w_q.zero;
    assign zero_d  = s2d_q.zero;
    assign nar_w   = s2w_q.nar;
    assign nar_d   = s2d_q.nar;
    assign long_d  = dlong_q;

endmodule

// File: tb/tb_posit_pair_decoder_pipe.sv
// Bench for posit_pair_decoder_pipe: directed vectors, randomized streams against an
// arithmetic posit model, stall, flush and asynchronous reset scenarios.
module tb_posit_pair_decoder_pipe;

    localparam int WIDTH = 8;
    localparam int EXP   = 2;
    localparam int REGW  = $clog2(WIDTH) + 1;
    localparam int MTS   = WIDTH - 3 - EXP;
    localparam int SCW   = REGW + EXP;

    typedef struct packed {
        logic                   sign;
        logic signed [REGW-1:0] regi;
        logic [EXP-1:0]         expo;
        logic [MTS-1:0]         mts;
        logic signed [SCW-1:0]  scale;
        logic                   zero;
        logic                   nar;
    } op_t;

    typedef struct packed {
        op_t  w;
        op_t  d;
        logic lng;
    } res_t;

    logic                   clk_i, rstn, flush_i, vld_i, rdy_o, vld_o, rdy_i;
    logic [WIDTH-1:0]       win, din;
    logic                   sign_w, sign_d, zero_w, zero_d, nar_w, nar_d, long_d;
    logic signed [REGW-1:0] regi_w, regi_d;
    logic [EXP-1:0]         exp_w, exp_d;
    logic [MTS-1:0]         mts_w, mts_d;
    logic signed [SCW-1:0]  scale_w, scale_d;

    int n_total = 0;
    int n_pass  = 0;

    posit_pair_decoder_pipe #(.WIDTH(WIDTH), .EXP(EXP)) dut (
        .clk_i(clk_i), .rstn(rstn), .flush_i(flush_i), .vld_i(vld_i), .rdy_o(rdy_o),
        .win(win), .din(din), .vld_o(vld_o), .rdy_i(rdy_i),
        .sign_w(sign_w), .sign_d(sign_d), .regi_w(regi_w), .regi_d(regi_d),
        .exp_w(exp_w), .exp_d(exp_d), .mts_w(mts_w), .mts_d(mts_d),
        .scale_w(scale_w), .scale_d(scale_d), .zero_w(zero_w), .zero_d(zero_d),
        .nar_w(nar_w), .nar_d(nar_d), .long_d(long_d)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference decode from the posit definition: magnitude as an integer, count the
    // regime run, then split the remaining bits into exponent and fraction.
    function automatic void ref_op(input logic [WIDTH-1:0] x, output op_t o, output int run);
        int xi, v, first, rest_len, rest, fl, k, e, f, sc;
        o   = '0;
        run = 0;
        xi  = int'(x);
        if (xi == 0) begin
            o.zero = 1'b1;
            return;
        end
        if (xi == (1 << (WIDTH - 1))) begin
            o.nar = 1'b1;
            return;
        end
        o.sign = x[WIDTH-1];
        v      = o.sign ? (1 << WIDTH) - xi : xi;
        first  = (v >= (1 << (WIDTH - 2))) ? 1 : 0;
        while (run < WIDTH - 1 && ((v >> (WIDTH - 2 - run)) & 1) == first) run++;
        k        = first ? run - 1 : -run;
        rest_len = WIDTH - 2 - run;
        if (rest_len < 0) rest_len = 0;
        rest = v % (1 << rest_len);
        if (rest_len >= EXP) begin
            fl = rest_len - EXP;
            e  = rest >> fl;
            f  = (rest % (1 << fl)) << (MTS - fl);
        end else begin
            e = rest << (EXP - rest_len);
            f = 0;
        end
        sc      = k * (1 << EXP) + e;
        o.regi  = k[REGW-1:0];
        o.expo  = e[EXP-1:0];
        o.mts   = f[MTS-1:0];
        o.scale = sc[SCW-1:0];
    endfunction

    function automatic res_t model(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] d);
        res_t r;
        int   rw, rd;
        ref_op(w, r.w, rw);
        ref_op(d, r.d, rd);
        r.lng = !(r.w.zero || r.w.nar || r.d.zero || r.d.nar) && (rd > rw);
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.w   = '{sign_w, regi_w, exp_w, mts_w, scale_w, zero_w, nar_w};
        r.d   = '{sign_d, regi_d, exp_d, mts_d, scale_d, zero_d, nar_d};
        r.lng = long_d;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_posit();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return WIDTH'(1);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // One cycle: sample handshake and outputs before the rising edge, return at negedge.
    task automatic tick(output bit acc, output bit cons, output bit vo, output bit ro,
                        output res_t obs);
        #1;
        acc  = vld_i && rdy_o;
        cons = vld_o && rdy_i;
        vo   = vld_o;
        ro   = rdy_o;
        obs  = observe();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; win = '0; din = '0;
        #3;
        n_total++;
        if (vld_o !== 1'b0) $display("FAIL reset_vld_o: got %b want 0", vld_o);
        else n_pass++;
        n_total++;
        if (rdy_o !== 1'b1) $display("FAIL reset_rdy_o: got %b want 1", rdy_o);
        else n_pass++;
        n_total++;
        if (observe() !== '0) $display("FAIL reset_outputs: got %h want 0", observe());
        else n_pass++;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] wt [4];
        logic [WIDTH-1:0] dt [4];
        res_t exp_r, obs, e3;
        wt = '{8'h40, 8'h7F, 8'h5A, 8'h00};
        dt = '{8'hC0, 8'h01, 8'h48, 8'h80};
        for (int i = 0; i < 4; i++) begin
            win = wt[i]; din = dt[i]; vld_i = 1'b1; rdy_i = 1'b1;
            @(posedge clk_i); #1;
            vld_i = 1'b0;
            n_total++;
            if (vld_o !== 1'b0) $display("FAIL latency_early[%0d]: vld_o got %b want 0", i, vld_o);
            else n_pass++;
            @(posedge clk_i); #1;
            obs   = observe();
            exp_r = model(wt[i], dt[i]);
            n_total++;
            if (vld_o !== 1'b1) $display("FAIL latency_two[%0d]: vld_o got %b want 1", i, vld_o);
            else n_pass++;
            n_total++;
            if (obs !== exp_r) $display("FAIL directed_model[%0d]: got %h want %h", i, obs, exp_r);
            else n_pass++;
            case (i)
                0: begin
                    n_total++;
                    if (obs.w !== '0 || obs.d.sign !== 1'b1 || obs.lng !== 1'b0)
                        $display("FAIL one_pair: got %h want w=0 sign_d=1 long=0", obs);
                    else n_pass++;
                end
                1: begin
                    n_total++;
                    if (int'(obs.w.regi) !== 6 || int'(obs.w.scale) !== 24 ||
                        int'(obs.d.regi) !== -6 || int'(obs.d.scale) !== -24 || obs.lng !== 1'b0)
                        $display("FAIL extreme_regime: got regi %0d/%0d scale %0d/%0d long %b want 6/-6 24/-24 0",
                                 obs.w.regi, obs.d.regi, obs.w.scale, obs.d.scale, obs.lng);
                    else n_pass++;
                end
                2: begin
                    n_total++;
                    if (obs.w.expo !== 2'd3 || obs.w.mts !== 3'b010 || int'(obs.w.scale) !== 3 ||
                        obs.d.expo !== 2'd1 || obs.d.mts !== 3'b000 || int'(obs.d.scale) !== 1)
                        $display("FAIL exp_mts_fields: got %h want w exp3 mts010 sc3, d exp1 mts0 sc1", obs);
                    else n_pass++;
                end
                default: begin
                    e3 = '0; e3.w.zero = 1'b1; e3.d.nar = 1'b1;
                    n_total++;
                    if (obs !== e3) $display("FAIL specials: got %h want %h", obs, e3);
                    else n_pass++;
                end
            endcase
            @(negedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t obs, prev_obs, front;
        bit acc, cons, vo, ro, prev_stall;
        logic [WIDTH-1:0] cw, cd;
        prev_stall = 1'b0;
        prev_obs   = '0;
        for (int i = 0; i < 340; i++) begin
            if (i < 300) begin
                cw = rand_posit(); cd = rand_posit();
                win = cw; din = cd;
                vld_i = ($urandom_range(0, 3) != 0);
                rdy_i = ($urandom_range(0, 3) != 0);
            end else begin
                vld_i = 1'b0; rdy_i = 1'b1;
            end
            tick(acc, cons, vo, ro, obs);
            if (prev_stall) begin
                n_total++;
                if (vo !== 1'b1 || obs !== prev_obs)
                    $display("FAIL rand_stall_hold: vld %b out %h want 1 %h", vo, obs, prev_obs);
                else n_pass++;
            end
            if (acc) q.push_back(model(cw, cd));
            if (cons) begin
                n_total++;
                if (q.size() == 0) $display("FAIL rand_extra_output: got %h want none", obs);
                else begin
                    front = q.pop_front();
                    if (obs !== front) $display("FAIL rand_result: got %h want %h", obs, front);
                    else n_pass++;
                end
            end
            prev_stall = vo && !cons;
            prev_obs   = obs;
        end
        n_total++;
        if (q.size() != 0) $display("FAIL rand_drain: %0d results missing want 0", q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] tw [4];
        logic [WIDTH-1:0] td [4];
        res_t q[$];
        res_t obs, prev_obs, front;
        bit acc, cons, vo, ro, prev_stall, saw_drop;
        int idx, got;
        for (int i = 0; i < 4; i++) begin
            tw[i] = rand_posit(); td[i] = rand_posit();
        end
        idx = 0; got = 0; prev_stall = 1'b0; saw_drop = 1'b0; prev_obs = '0;
        for (int c = 0; c < 20; c++) begin
            rdy_i = !(c >= 2 && c <= 4);
            vld_i = (idx < 4);
            if (idx < 4) begin
                win = tw[idx]; din = td[idx];
            end
            tick(acc, cons, vo, ro, obs);
            if (!ro) begin
                saw_drop = 1'b1;
                n_total++;
                if (vo !== 1'b1) $display("FAIL b2b_drop_when_full: vld_o %b want 1 while rdy_o low", vo);
                else n_pass++;
            end
            if (prev_stall) begin
                n_total++;
                if (vo !== 1'b1 || obs !== prev_obs)
                    $display("FAIL b2b_stall_hold: vld %b out %h want 1 %h", vo, obs, prev_obs);
                else n_pass++;
            end
            if (acc) begin
                q.push_back(model(tw[idx], td[idx]));
                idx++;
            end
            if (cons) begin
                got++;
                n_total++;
                if (q.size() == 0) $display("FAIL b2b_extra_output: got %h want none", obs);
                else begin
                    front = q.pop_front();
                    if (obs !== front) $display("FAIL b2b_result[%0d]: got %h want %h", got - 1, obs, front);
                    else n_pass++;
                end
            end
            prev_stall = vo && !cons;
            prev_obs   = obs;
        end
        n_total++;
        if (!saw_drop) $display("FAIL b2b_rdy_drop: rdy_o never low want low during stall");
        else n_pass++;
        n_total++;
        if (got != 4 || idx != 4) $display("FAIL b2b_count: got %0d out %0d in want 4 4", got, idx);
        else n_pass++;
    endtask

    task automatic test_flush();
        res_t obs;
        bit acc, cons, vo, ro;
        int leaks;
        flush_i = 1'b0; vld_i = 1'b1; rdy_i = 1'b0;
        win = rand_posit(); din = rand_posit();
        tick(acc, cons, vo, ro, obs);
        win = rand_posit(); din = rand_posit();
        tick(acc, cons, vo, ro, obs);
        #1;
        n_total++;
        if (rdy_o !== 1'b0 || vld_o !== 1'b1)
            $display("FAIL flush_full: rdy_o %b vld_o %b want 0 1", rdy_o, vld_o);
        else n_pass++;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; vld_i = 1'b0;
        n_total++;
        if (vld_o !== 1'b0 || rdy_o !== 1'b1)
            $display("FAIL flush_clear: vld_o %b rdy_o %b want 0 1", vld_o, rdy_o);
        else n_pass++;
        @(negedge clk_i);
        rdy_i = 1'b1;
        leaks = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (vld_o !== 1'b0) leaks++;
        end
        n_total++;
        if (leaks != 0) $display("FAIL flush_no_leak: %0d valid cycles want 0", leaks);
        else n_pass++;
        @(negedge clk_i);
    endtask

    task automatic test_async_reset();
        res_t obs;
        bit acc, cons, vo, ro;
        int leaks;
        vld_i = 1'b1; rdy_i = 1'b1;
        win = 8'h5A; din = 8'h7F;
        tick(acc, cons, vo, ro, obs);
        win = 8'h48; din = 8'h01;
        tick(acc, cons, vo, ro, obs);
        #2;
        n_total++;
        if (vld_o !== 1'b1) $display("FAIL areset_precond: vld_o %b want 1", vld_o);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++;
        if (vld_o !== 1'b0 || rdy_o !== 1'b1 || observe() !== '0)
            $display("FAIL areset_immediate: vld_o %b rdy_o %b out %h want 0 1 0", vld_o, rdy_o, observe());
        else n_pass++;
        vld_i = 1'b0;
        @(negedge clk_i);
        rstn = 1'b1;
        leaks = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (vld_o !== 1'b0) leaks++;
        end
        n_total++;
        if (leaks != 0) $display("FAIL areset_discard: %0d valid cycles want 0", leaks);
        else n_pass++;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
